// File: rtl/truth_table_checker_if.sv
// Handshake and result bus between truth_table_checker and the block that
// starts runs, supplies the expected table and hosts the combinational DUT.
interface truth_table_checker_if #(
    parameter int N_IN = 2
) ();
    localparam int V = 2**N_IN;

    logic              start;
    logic [V-1:0]      expected;
    logic [N_IN-1:0]   dut_in;
    logic              dut_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [V-1:0]      captured;
    logic [V-1:0]      fail_mask;
    logic [N_IN:0]     fail_count;

    // Checker side: consumes start/expected/dut_out, produces stimulus and results.
    modport slave (
        input  start, expected, dut_out,
        output dut_in, busy, done, pass, captured, fail_mask, fail_count
    );

    // Controller/DUT side: the mirror image of the checker.
    modport master (
        output start, expected, dut_out,
        input  dut_in, busy, done, pass, captured, fail_mask, fail_count
    );
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive truth-table checker for small combinational blocks. Walks every
// input vector, holds each for SETTLE cycles, samples the DUT response one
// cycle later and compares it against a latched expected mask.
module truth_table_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_checker_if.slave  tt
);
    localparam int V     = 2**N_IN;
    localparam int FC_W  = N_IN + 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  IDX_LAST = N_IN'(V - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [V-1:0]      exp_q, exp_d;
    logic [V-1:0]      cap_q, cap_d;
    logic [V-1:0]      fm_q, fm_d;
    logic [FC_W-1:0]   fc_q, fc_d;
    logic              pass_q, pass_d;
    logic              launch;
    logic              mismatch;
    logic              busy, done;

    // A run may be accepted from IDLE or straight out of DONE, so a held start
    // re-launches on the edge that leaves DONE (run period V*(SETTLE+1)+1).
    assign launch   = tt.start && ((state_q == IDLE) || (state_q == DONE));
    assign mismatch = tt.dut_out ^ exp_q[idx_q];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tt.start) state_d = DRIVE;
            DRIVE:   if (cnt_q == CNT_LAST) state_d = SAMPLE;
            SAMPLE:  state_d = (idx_q == IDX_LAST) ? DONE : DRIVE;
            DONE:    state_d = tt.start ? DRIVE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded status outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            DRIVE, SAMPLE: busy = 1'b1;
            DONE:          done = 1'b1;
            default:       ;
        endcase
    end

    // Datapath next-state: vector index, settle counter and result capture
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        exp_d  = exp_q;
        cap_d  = cap_q;
        fm_d   = fm_q;
        fc_d   = fc_q;
        pass_d = pass_q;
        if (launch) begin
            idx_d  = '0;
            cnt_d  = '0;
            exp_d  = tt.expected;
            cap_d  = '0;
            fm_d   = '0;
            fc_d   = '0;
            pass_d = 1'b0;
        end else if (state_q == DRIVE) begin
            if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
        end else if (state_q == SAMPLE) begin
            cap_d[idx_q] = tt.dut_out;
            fm_d[idx_q]  = mismatch;
            fc_d         = fc_q + FC_W'(mismatch);
            if (idx_q == IDX_LAST) begin
                // Verdict includes the mismatch of the vector sampled right now.
                pass_d = (fc_q == '0) && !mismatch;
            end else begin
                idx_d = idx_q + 1'b1;
                cnt_d = '0;
            end
        end
    end

    // Datapath registers, cleared asynchronously together with the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            exp_q  <= '0;
            cap_q  <= '0;
            fm_q   <= '0;
            fc_q   <= '0;
            pass_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            exp_q  <= exp_d;
            cap_q  <= cap_d;
            fm_q   <= fm_d;
            fc_q   <= fc_d;
            pass_q <= pass_d;
        end
    end

    // The stimulus is the vector index itself, so it only moves when idx does.
    assign tt.dut_in     = idx_q;
    assign tt.busy       = busy;
    assign tt.done       = done;
    assign tt.pass       = pass_q;
    assign tt.captured   = cap_q;
    assign tt.fail_mask  = fm_q;
    assign tt.fail_count = fc_q;

endmodule
